// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single integer register-file write port between NREQ write-back
//   requesters (ALU, LSU, MUL/DIV) using round-robin arbitration, and keeps a
//   per-register busy scoreboard that the issue stage uses to stall on RAW/WAW
//   hazards.
//
// Handshake: requester i presents req_valid[i] with req_rd/req_wdata and holds
//   all three stable until req_ready[i]. A transfer is req_valid[i] &&
//   req_ready[i] at a rising clock edge. Valid may only drop after a transfer.
//   The same valid/ready rule applies to the scoreboard reservation
//   (sb_set_valid / sb_set_ready).
//
// Ports:
//   clock, rst_n            clock (rising edge), async active-low reset
//   req_valid/rd/wdata      per-requester write-back request (packed by index)
//   req_ready               one-hot-or-zero grant
//   rf_wen/rf_rd/rf_wdata   registered register-file write port
//   sb_set_valid/rd/ready   scoreboard reservation from issue
//   rs1_q, rs2_q            issue-stage source operand indices
//   rs1_busy, rs2_busy      operand has an outstanding write
//   flush                   clears the whole scoreboard
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_wen,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 sb_set_valid,
  input  logic [4:0]           sb_set_rd,
  output logic                 sb_set_ready,
  input  logic [4:0]           rs1_q,
  input  logic [4:0]           rs2_q,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 flush
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_wen_q;
  logic [4:0]      rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [31:0]     busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic            found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   idx;
  int              cand;
  logic            xfer;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_wdata;
  logic            set_fire;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      idx = PW'(cand);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end

  // Grants are suppressed while reset is asserted.
  assign req_ready = rst_n ? grant : '0;
  assign xfer      = found && rst_n;
  assign win_rd    = req_rd[5*win_idx +: 5];
  assign win_wdata = req_wdata[XLEN*win_idx +: XLEN];

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Write port: one-cycle registered latency. A transfer to x0 completes the
  // handshake but produces no write and leaves rf_rd/rf_wdata untouched.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rf_wen_q <= xfer && (win_rd != 5'd0);
      if (xfer && (win_rd != 5'd0)) begin
        rf_rd_q    <= win_rd;
        rf_wdata_q <= win_wdata;
      end
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  // Scoreboard. Priority (lowest to highest): clear on commit, set on
  // reservation, flush. x0 is never marked busy.
  assign sb_set_ready = !busy_q[sb_set_rd] || (sb_set_rd == 5'd0);
  assign set_fire     = sb_set_valid && sb_set_ready && (sb_set_rd != 5'd0);

  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_rd_q] = 1'b0;
    if (set_fire) busy_d[sb_set_rd] = 1'b1;
    if (flush)    busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = (rs1_q != 5'd0) && busy_q[rs1_q];
  assign rs2_busy = (rs2_q != 5'd0) && busy_q[rs2_q];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vectors, expected register-file
// writes pushed into a queue at grant time and popped by a monitor whenever
// rf_wen is seen.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int EW   = 5 + XLEN;

  logic                 clock;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_wen;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic                 sb_set_valid;
  logic [4:0]           sb_set_rd;
  logic                 sb_set_ready;
  logic [4:0]           rs1_q;
  logic [4:0]           rs2_q;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 flush;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rf_wen       (rf_wen),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .sb_set_ready (sb_set_ready),
    .rs1_q        (rs1_q),
    .rs2_q        (rs2_q),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .flush        (flush)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    req_rd[5*i +: 5]         = rd;
    req_wdata[XLEN*i +: XLEN] = d;
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (rst_n && rf_wen === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL rf_write_unexpected actual rd=%0d data=0x%0h required=no write", rf_rd, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd, rf_wdata} !== e) begin
          failures = failures + 1;
          $display("FAIL rf_write actual rd=%0d data=0x%0h required rd=%0d data=0x%0h",
                   rf_rd, rf_wdata, e[EW-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    req_valid    = '1;
    req_rd       = '0;
    req_wdata    = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    rs1_q        = '0;
    rs2_q        = '0;
    flush        = 1'b0;

    // Reset state: grants suppressed even with all requesters valid.
    at_neg();
    chk("reset_req_ready", XLEN'(req_ready), 0);
    chk("reset_rf_wen", XLEN'(rf_wen), 0);
    chk("reset_rf_rd", XLEN'(rf_rd), 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    req_valid = '0;
    #7 rst_n = 1'b1;

    // 1. Single ALU write.
    tick();
    req_valid = 3'b001;
    set_req(0, 5'd5, 64'h1234);
    at_neg();
    chk("t1_grant", XLEN'(req_ready), 64'b001);
    push_exp(5'd5, 64'h1234);
    tick();
    req_valid = '0;
    at_neg();
    tick();
    at_neg();
    chk("t1_wen_low_after", XLEN'(rf_wen), 0);

    // 3. x0 write from req 2 (ptr=1 -> req 2 wins); leaves ptr at 0.
    tick();
    req_valid = 3'b100;
    set_req(2, 5'd0, 64'hFFFF);
    rs1_q = 5'd0;
    at_neg();
    chk("t3_grant", XLEN'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    at_neg();
    chk("t3_no_wen", XLEN'(rf_wen), 0);
    chk("t3_rd_held", XLEN'(rf_rd), 5);
    chk("t3_wdata_held", rf_wdata, 64'h1234);
    chk("t3_x0_not_busy", XLEN'(rs1_busy), 0);

    // 2. All three valid from ptr=0: grants 0,1,2 in order.
    tick();
    req_valid = 3'b111;
    set_req(0, 5'd1, 64'hA1);
    set_req(1, 5'd2, 64'hA2);
    set_req(2, 5'd3, 64'hA3);
    at_neg();
    chk("t2_grant0", XLEN'(req_ready), 64'b001);
    push_exp(5'd1, 64'hA1);
    tick();
    req_valid = 3'b110;
    at_neg();
    chk("t2_grant1", XLEN'(req_ready), 64'b010);
    push_exp(5'd2, 64'hA2);
    tick();
    req_valid = 3'b100;
    at_neg();
    chk("t2_grant2", XLEN'(req_ready), 64'b100);
    push_exp(5'd3, 64'hA3);
    tick();
    // ptr back at 0; only req 1 and 2 valid -> req 1 first.
    req_valid = 3'b110;
    set_req(1, 5'd10, 64'hB1);
    set_req(2, 5'd11, 64'hB2);
    at_neg();
    chk("t2b_grant1", XLEN'(req_ready), 64'b010);
    push_exp(5'd10, 64'hB1);
    tick();
    req_valid = 3'b100;
    at_neg();
    chk("t2b_grant2", XLEN'(req_ready), 64'b100);
    push_exp(5'd11, 64'hB2);
    tick();
    req_valid = '0;
    tick();
    tick();

    // 4. Scoreboard set / WAW block / clear on commit. ptr=0.
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd7;
    at_neg();
    chk("t4_set_ready", XLEN'(sb_set_ready), 1);
    tick();
    rs1_q = 5'd7;
    rs2_q = 5'd8;
    req_valid = 3'b010;
    set_req(1, 5'd7, 64'h77);
    at_neg();
    chk("t4_rs1_busy", XLEN'(rs1_busy), 1);
    chk("t4_rs2_not_busy", XLEN'(rs2_busy), 0);
    chk("t4_waw_block", XLEN'(sb_set_ready), 0);
    chk("t4_lsu_grant", XLEN'(req_ready), 64'b010);
    push_exp(5'd7, 64'h77);
    tick();
    sb_set_valid = 1'b0;
    req_valid    = '0;
    at_neg();
    chk("t4_busy_during_wen", XLEN'(rs1_busy), 1);
    tick();
    at_neg();
    chk("t4_busy_cleared", XLEN'(rs1_busy), 0);
    chk("t4_set_ready_again", XLEN'(sb_set_ready), 1);

    // 5. Write x9 (not busy) and reserve x9 in the commit cycle: set wins. ptr=2.
    tick();
    req_valid = 3'b100;
    set_req(2, 5'd9, 64'h99);
    rs1_q = 5'd9;
    at_neg();
    chk("t5_grant", XLEN'(req_ready), 64'b100);
    push_exp(5'd9, 64'h99);
    tick();
    req_valid    = '0;
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd9;
    at_neg();
    chk("t5_set_ready", XLEN'(sb_set_ready), 1);
    tick();
    sb_set_valid = 1'b0;
    at_neg();
    chk("t5_set_wins", XLEN'(rs1_busy), 1);

    // 6. Busy x3/x4, in-flight write, flush with a coincident set. ptr=0.
    tick();
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd3;
    tick();
    sb_set_rd    = 5'd4;
    tick();
    sb_set_valid = 1'b0;
    rs1_q = 5'd3;
    rs2_q = 5'd4;
    req_valid = 3'b001;
    set_req(0, 5'd12, 64'hC0FFEE);
    at_neg();
    chk("t6_x3_busy", XLEN'(rs1_busy), 1);
    chk("t6_x4_busy", XLEN'(rs2_busy), 1);
    chk("t6_grant", XLEN'(req_ready), 64'b001);
    push_exp(5'd12, 64'hC0FFEE);
    tick();
    req_valid    = '0;
    flush        = 1'b1;
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd20;
    at_neg();
    chk("t6_inflight_wen", XLEN'(rf_wen), 1);
    tick();
    flush        = 1'b0;
    sb_set_valid = 1'b0;
    at_neg();
    chk("t6_flush_x3", XLEN'(rs1_busy), 0);
    chk("t6_flush_x4", XLEN'(rs2_busy), 0);
    tick();
    rs1_q = 5'd9;
    rs2_q = 5'd20;
    at_neg();
    chk("t6_flush_x9", XLEN'(rs1_busy), 0);
    chk("t6_flush_set_ignored", XLEN'(rs2_busy), 0);

    // Reserve x5, then reset in the cycle a write is in flight. ptr=1.
    tick();
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd5;
    tick();
    sb_set_valid = 1'b0;
    rs1_q = 5'd5;
    req_valid = 3'b010;
    set_req(1, 5'd13, 64'hDEAD);
    at_neg();
    chk("t6_x5_busy", XLEN'(rs1_busy), 1);
    chk("t6_rst_grant", XLEN'(req_ready), 64'b010);
    tick();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("t6_rst_wen", XLEN'(rf_wen), 0);
    at_neg();
    chk("t6_rst_rf_rd", XLEN'(rf_rd), 0);
    chk("t6_rst_x5_clear", XLEN'(rs1_busy), 0);
    #2 rst_n = 1'b1;
    tick();
    at_neg();
    chk("t6_rst_no_pulse", XLEN'(rf_wen), 0);
    tick();
    // ptr must be 0: with 0 and 2 valid, 0 wins.
    req_valid = 3'b101;
    set_req(0, 5'd14, 64'hE0);
    set_req(2, 5'd15, 64'hE2);
    at_neg();
    chk("t6_ptr_reset", XLEN'(req_ready), 64'b001);
    push_exp(5'd14, 64'hE0);
    tick();
    req_valid = 3'b100;
    at_neg();
    push_exp(5'd15, 64'hE2);
    tick();
    req_valid = '0;
    tick();
    tick();
    at_neg();

    chk("queue_drained", XLEN'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single integer register-file write port (rd / rd_wdata / reg_wen) between NREQ write-back requesters: ALU, LSU, MUL/DIV.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Keeps a per-register busy scoreboard so the issue stage can stall on RAW/WAW hazards.
- Sits between the execute units and the regs block; its registered outputs drive the regs write port directly.

Parameters:
- NREQ, 3, number of write-back requesters (2..4).
- XLEN, 64, data width.

Ports:
- clock  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a pending write.
- req_rd  in  5*NREQ  destination of requester i, bits [5i+4:5i].
- req_wdata  in  XLEN*NREQ  data of requester i, bits [XLEN*i+XLEN-1:XLEN*i].
- req_ready  out  NREQ  grant to requester i, one-hot or zero.
- rf_wen  out  1  register-file write enable (to reg_wen).
- rf_rd  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- sb_set_valid  in  1  issue stage dispatches an instruction writing sb_set_rd.
- sb_set_rd  in  5  destination being reserved.
- sb_set_ready  out  1  reservation accepted (no WAW conflict).
- rs1_q, rs2_q  in  5 each  issue-stage source operands.
- rs1_busy, rs2_busy  out  1 each  operand has an outstanding write.
- flush  in  1  pipeline flush; clears the scoreboard.

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_rd=0, rf_wdata=0.
  - RR pointer=0.
  - All 32 busy bits=0.
  - req_ready=0 while in reset.
- Arbitration, combinational:
  - Search starts at index ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - At most one grant per cycle. No valid → req_ready=0.
- Handshake:
  - A transfer occurs when req_valid[i]&&req_ready[i] at a rising edge.
  - The requester holds valid, rd and wdata stable until ready.
  - It may not drop valid without a transfer.
- Pointer update: on a transfer from i, ptr <= (i+1) mod NREQ. Otherwise ptr holds.
- Write port, registered, one-cycle latency:
  - A transfer in cycle T drives rf_wen=1 with rf_rd/rf_wdata from the winner in cycle T+1.
  - rf_wen=0 in any cycle following a no-transfer cycle.
  - rf_rd/rf_wdata hold their last value when rf_wen=0.
- x0 write: a transfer with rd=0 completes the handshake but produces rf_wen=0 in T+1.
- Scoreboard set:
  - sb_set_ready = !busy[sb_set_rd] || sb_set_rd==0, combinational.
  - On sb_set_valid&&sb_set_ready&&sb_set_rd!=0&&!flush, busy[sb_set_rd] <= 1.
  - rd=0 is never marked busy.
- Scoreboard clear:
  - In any cycle with rf_wen=1, busy[rf_rd] <= 0 at the closing edge.
  - busy is therefore low from T+2, the same cycle the regs read path (no bypass) returns the new value.
- Same register set and cleared in the same cycle: set wins (busy stays 1).
- Query:
  - rs1_busy = busy[rs1_q]; rs2_busy = busy[rs2_q].
  - Index 0 always reads 0.
- Flush: all busy bits <= 0 at the edge; a coincident set is ignored.
- Flush does not affect the arbiter, ptr or the pending rf_* register: an in-flight write still commits.
- Reset mid-operation: an in-flight registered write is discarded and no rf_wen pulse follows.
- Write-back of a register not marked busy is legal: the write happens and busy stays 0.

Test Plan:
1. After reset, ALU (i=0) presents rd=5, wdata=0x1234 → req_ready[0]=1 the same cycle; rf_wen=1, rf_rd=5, rf_wdata=0x1234 the next cycle; rf_wen=0 the cycle after.
2. All three valid and held for 3 cycles from ptr=0, rd=1/2/3 → grants 0,1,2 in successive cycles; rf_rd=1,2,3 in cycles +1..+3. Then only req 1 and req 2 valid with ptr=0 → req 1 granted first.
3. Requester presents rd=0, wdata=0xFFFF → handshake completes, rf_wen stays 0, no busy change.
4. Scoreboard:
   - Set rd=7 → rs1_q=7 shows rs1_busy=1.
   - A second set on rd=7 → sb_set_ready=0.
   - LSU writes rd=7 → rf_wen in T+1, busy=0 in T+2, sb_set_ready=1 in T+2.
5. Same register set and cleared together: rf_wen=1 with rf_rd=9 while sb_set_valid with rd=9 → busy[9]=1 afterwards.
6. Busy on x3 and x4, a transfer in flight, then flush → busy all 0 next cycle and the in-flight write still appears on rf_*. Then assert rst_n=0 mid-transfer → rf_wen=0 immediately, ptr=0, busy all 0.
